// File: rtl/cr_writer.sv
// Key-guarded runtime loader for the CR definition table; seals the table and serves it read-only to the monitor.
// Optional readback through the DATA/INDEX registers is built when CR_READBACK_EN is defined.
module cr_writer #(
  parameter int unsigned ENTRIES   = 16,
  parameter logic [13:0] BASE_ADDR = 14'h00C8,
  parameter logic [15:0] KEY0      = 16'hA5C3,
  parameter logic [15:0] KEY1      = 16'h5A3C
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic [7:0]  cr_rd_idx,
  output logic [15:0] cr_rd_data,
  output logic [7:0]  cr_count,
  output logic        cr_valid
);

  // state  | meaning
  // IDLE   | locked, waiting for KEY0
  // ARMED  | KEY0 seen, waiting for KEY1
  // LOAD   | DATA writes append entries
  // SEALED | table frozen and visible to the monitor
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ARMED  = 2'b01,
    S_LOAD   = 2'b10,
    S_SEALED = 2'b11
  } state_t;

  localparam int unsigned IDX_W     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [7:0]  ENTRIES_L = 8'(ENTRIES);

  state_t      state, state_nxt;
  logic [7:0]  count, count_nxt;
  logic        err, err_nxt;
  logic        store;
  logic [15:0] entry [ENTRIES];

  // Unsigned wrap makes addresses below BASE_ADDR miss as well.
  logic [13:0] off_full;
  logic [1:0]  offset;
  logic        hit, wr_acc, rd_acc, wr_ctrl, wr_data, bad_we;

  assign off_full = per_addr - BASE_ADDR;
  assign offset   = off_full[1:0];
  assign hit      = per_en && (off_full < 14'd3);
  assign wr_acc   = hit && (per_we == 2'b11);
  assign rd_acc   = hit && (per_we == 2'b00);
  assign wr_ctrl  = wr_acc && (offset == 2'd0);
  assign wr_data  = wr_acc && (offset == 2'd1);
  assign bad_we   = hit && (per_we != 2'b00) && (per_we != 2'b11) && (offset != 2'd2);

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      count <= '0;
      err   <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) entry[i] <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      err   <= err_nxt;
      if (store) entry[count[IDX_W-1:0]] <= per_din;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    err_nxt   = err | bad_we;
    store     = 1'b0;
    case (state)
      S_IDLE: begin
        if (wr_ctrl && (per_din == KEY0)) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (wr_ctrl && (per_din == KEY1)) begin
          state_nxt = S_LOAD;
          count_nxt = '0;
        end else if (wr_ctrl || wr_data) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end
      end
      S_LOAD: begin
        if (wr_data) begin
          store     = 1'b1;
          count_nxt = count + 8'd1;
          if ((count + 8'd1) == ENTRIES_L) state_nxt = S_SEALED;
        end else if (wr_ctrl) begin
          if (per_din == 16'h0001) begin
            state_nxt = S_SEALED;
          end else begin
            state_nxt = S_IDLE;
            err_nxt   = 1'b1;
            count_nxt = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign cr_valid   = (state == S_SEALED);
  assign cr_count   = count;
  assign cr_rd_data = (cr_valid && (cr_rd_idx < count)) ? entry[cr_rd_idx[IDX_W-1:0]] : 16'h0000;

  logic [15:0] stat;
  assign stat = {err, state, 5'b00000, count};

`ifdef CR_READBACK_EN
  logic [7:0]  rb_idx;
  logic [15:0] rb_data;
  logic        wr_index, rd_data_reg;

  assign wr_index    = wr_acc && (offset == 2'd2);
  assign rd_data_reg = rd_acc && (offset == 2'd1);
  assign rb_data     = (cr_valid && (rb_idx < count)) ? entry[rb_idx[IDX_W-1:0]] : 16'h0000;

  // Pointer wraps to 0 once it passes the last loaded entry.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      rb_idx <= '0;
    end else if (wr_index) begin
      rb_idx <= per_din[7:0];
    end else if (rd_data_reg) begin
      if (({1'b0, rb_idx} + 9'd1) >= {1'b0, count}) rb_idx <= '0;
      else rb_idx <= rb_idx + 8'd1;
    end
  end

  always_comb begin
    per_dout = '0;
    if (rd_acc) begin
      case (offset)
        2'd0:    per_dout = stat;
        2'd1:    per_dout = rb_data;
        2'd2:    per_dout = {8'h00, rb_idx};
        default: per_dout = '0;
      endcase
    end
  end
`else
  always_comb begin
    per_dout = '0;
    if (rd_acc && (offset == 2'd0)) per_dout = stat;
  end
`endif

endmodule

// File: tb/tb_cr_writer.sv
// Self-checking bench for cr_writer: directed scenarios plus randomized bus traffic against a queue-based table model.
module tb_cr_writer;

  localparam logic [13:0] BASE = 14'h00C8;
  localparam logic [15:0] K0   = 16'hA5C3;
  localparam logic [15:0] K1   = 16'h5A3C;
  localparam int          NENT = 16;

  logic        mclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] per_addr = '0;
  logic [15:0] per_din = '0;
  logic        per_en = 1'b0;
  logic [1:0]  per_we = '0;
  logic [15:0] per_dout;
  logic [7:0]  cr_rd_idx = '0;
  logic [15:0] cr_rd_data;
  logic [7:0]  cr_count;
  logic        cr_valid;

  int vectors = 0;
  int miscompares = 0;

  cr_writer dut (
    .mclk       (mclk),
    .reset_n    (reset_n),
    .per_addr   (per_addr),
    .per_din    (per_din),
    .per_en     (per_en),
    .per_we     (per_we),
    .per_dout   (per_dout),
    .cr_rd_idx  (cr_rd_idx),
    .cr_rd_data (cr_rd_data),
    .cr_count   (cr_count),
    .cr_valid   (cr_valid)
  );

  always #5 mclk = ~mclk;

`ifdef CR_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  // Reference model: phase 0 idle, 1 armed, 2 load, 3 sealed; the table is a queue.
  int          m_state;
  bit          m_err;
  logic [15:0] m_tab[$];
  logic [7:0]  m_idx;

  function automatic void m_reset();
    m_state = 0;
    m_err   = 1'b0;
    m_tab.delete();
    m_idx   = '0;
  endfunction

  function automatic logic [15:0] m_entry(int idx);
    if (m_state == 3 && idx < m_tab.size()) return m_tab[idx];
    return 16'h0000;
  endfunction

  function automatic logic [15:0] m_read(int off, logic [1:0] we);
    logic [1:0] st;
    st = 2'(m_state);
    if (we != 2'b00 || off < 0 || off > 2) return 16'h0000;
    if (off == 0) return {m_err, st, 5'b0, 8'(m_tab.size())};
    if (!RB) return 16'h0000;
    if (off == 1) return m_entry(int'(m_idx));
    return {8'h00, m_idx};
  endfunction

  function automatic void m_write(int off, logic [1:0] we, logic [15:0] d);
    if (off < 0 || off > 2) return;
    if (we == 2'b00) begin
      if (RB && off == 1) m_idx = (int'(m_idx) + 1 >= m_tab.size()) ? 8'd0 : m_idx + 8'd1;
      return;
    end
    if (we != 2'b11) begin
      if (off <= 1) m_err = 1'b1;
      return;
    end
    if (off == 2) begin
      if (RB) m_idx = d[7:0];
      return;
    end
    case (m_state)
      0: if (off == 0 && d == K0) m_state = 1;
      1: begin
        if (off == 0 && d == K1) begin
          m_state = 2;
          m_tab.delete();
        end else begin
          m_state = 0;
          m_err   = 1'b1;
        end
      end
      2: begin
        if (off == 1) begin
          m_tab.push_back(d);
          if (m_tab.size() == NENT) m_state = 3;
        end else if (d == 16'h0001) begin
          m_state = 3;
        end else begin
          m_state = 0;
          m_err   = 1'b1;
          m_tab.delete();
        end
      end
      default: ;
    endcase
  endfunction

  // One bus cycle: drive after the falling edge, sample per_dout mid-cycle, step the model at the rising edge.
  task automatic bus(input int off, input logic [1:0] we, input logic [15:0] din,
                     output logic [15:0] rd, output logic [15:0] exp);
    @(negedge mclk);
    per_en   = 1'b1;
    per_addr = 14'(int'(BASE) + off);
    per_we   = we;
    per_din  = din;
    exp      = m_read(off, we);
    #1 rd = per_dout;
    @(posedge mclk);
    m_write(off, we, din);
    #1;
    per_en = 1'b0;
    per_we = 2'b00;
  endtask

  task automatic apply_reset();
    @(negedge mclk);
    reset_n = 1'b0;
    per_en  = 1'b0;
    per_we  = 2'b00;
    m_reset();
    #2 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] rd, exp;
    apply_reset();
    vectors++;
    if (cr_count !== 8'd0 || cr_valid !== 1'b0 || cr_rd_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_outputs: count=%0d valid=%b data=%h, want 0/0/0000", cr_count, cr_valid, cr_rd_data);
    end
    bus(0, 2'b00, 16'h0, rd, exp);
    vectors++;
    if (rd !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_stat: got %h want 0000", rd);
    end
  endtask

  task automatic test_basic_seal();
    logic [15:0] rd, exp;
    apply_reset();
    bus(0, 2'b11, K0, rd, exp);
    bus(0, 2'b11, K1, rd, exp);
    bus(1, 2'b11, 16'h1000, rd, exp);
    bus(1, 2'b11, 16'h1010, rd, exp);
    bus(1, 2'b11, 16'h1020, rd, exp);
    bus(0, 2'b11, 16'h0001, rd, exp);
    bus(0, 2'b00, 16'h0, rd, exp);
    vectors++;
    if (rd !== 16'h6003 || exp !== 16'h6003) begin
      miscompares++;
      $display("FAIL basic_stat: got %h want 6003", rd);
    end
    vectors++;
    if (cr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_valid: got %b want 1", cr_valid);
    end
    cr_rd_idx = 8'd1;
    #1;
    vectors++;
    if (cr_rd_data !== 16'h1010) begin
      miscompares++;
      $display("FAIL basic_rd1: got %h want 1010", cr_rd_data);
    end
    cr_rd_idx = 8'd3;
    #1;
    vectors++;
    if (cr_rd_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL basic_rd3: got %h want 0000", cr_rd_data);
    end
  endtask

  task automatic test_bad_sequence();
    logic [15:0] rd, exp;
    apply_reset();
    bus(0, 2'b11, K0, rd, exp);
    bus(1, 2'b11, 16'h1234, rd, exp);
    bus(0, 2'b00, 16'h0, rd, exp);
    vectors++;
    if (rd !== 16'h8000) begin
      miscompares++;
      $display("FAIL badseq_stat: got %h want 8000", rd);
    end
    bus(0, 2'b11, K0, rd, exp);
    bus(0, 2'b11, K1, rd, exp);
    bus(0, 2'b00, 16'h0, rd, exp);
    vectors++;
    if (rd !== 16'hC000) begin
      miscompares++;
      $display("FAIL badseq_relock: got %h want c000", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd, exp;
    apply_reset();
    bus(0, 2'b11, K0, rd, exp);
    bus(0, 2'b11, K1, rd, exp);
    for (int i = 0; i < NENT; i++) begin
      bus(1, 2'b11, 16'($urandom), rd, exp);
      vectors++;
      if (cr_valid !== (i == NENT - 1) || cr_count !== 8'(i + 1)) begin
        miscompares++;
        $display("FAIL b2b_step%0d: valid=%b count=%0d want %b/%0d", i, cr_valid, cr_count, (i == NENT - 1), i + 1);
      end
    end
    bus(0, 2'b00, 16'h0, rd, exp);
    vectors++;
    if (rd !== 16'h6010) begin
      miscompares++;
      $display("FAIL b2b_stat: got %h want 6010", rd);
    end
    bus(1, 2'b11, 16'hDEAD, rd, exp);
    vectors++;
    if (cr_count !== 8'd16) begin
      miscompares++;
      $display("FAIL b2b_17th: count=%0d want 16", cr_count);
    end
    for (int i = 0; i <= NENT; i++) begin
      cr_rd_idx = 8'(i);
      #1;
      vectors++;
      if (cr_rd_data !== m_entry(i)) begin
        miscompares++;
        $display("FAIL b2b_entry%0d: got %h want %h", i, cr_rd_data, m_entry(i));
      end
    end
  endtask

  task automatic test_partial_we();
    logic [15:0] rd, exp;
    apply_reset();
    bus(0, 2'b11, K0, rd, exp);
    bus(0, 2'b11, K1, rd, exp);
    bus(1, 2'b11, 16'h0AAA, rd, exp);
    bus(1, 2'b11, 16'h0BBB, rd, exp);
    bus(1, 2'b01, 16'h0CCC, rd, exp);
    bus(0, 2'b00, 16'h0, rd, exp);
    vectors++;
    if (rd !== 16'hC002) begin
      miscompares++;
      $display("FAIL partial_stat: got %h want c002", rd);
    end
    bus(0, 2'b11, 16'h0001, rd, exp);
    cr_rd_idx = 8'd2;
    #1;
    vectors++;
    if (cr_rd_data !== 16'h0000 || cr_count !== 8'd2) begin
      miscompares++;
      $display("FAIL partial_nostore: data=%h count=%0d want 0000/2", cr_rd_data, cr_count);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] rd, exp;
    apply_reset();
    bus(0, 2'b11, K0, rd, exp);
    bus(0, 2'b11, K1, rd, exp);
    for (int i = 0; i < 5; i++) bus(1, 2'b11, 16'h2000 + 16'(i), rd, exp);
    #2 reset_n = 1'b0;
    per_en   = 1'b1;
    per_addr = BASE;
    per_we   = 2'b00;
    #1;
    vectors++;
    if (cr_count !== 8'd0 || cr_valid !== 1'b0 || per_dout !== 16'h0000) begin
      miscompares++;
      $display("FAIL areset_load: count=%0d valid=%b stat=%h want 0/0/0000", cr_count, cr_valid, per_dout);
    end
    per_en = 1'b0;
    m_reset();
    @(negedge mclk);
    reset_n = 1'b1;
    bus(0, 2'b11, K0, rd, exp);
    bus(0, 2'b11, K1, rd, exp);
    for (int i = 0; i < 5; i++) bus(1, 2'b11, 16'h3000 + 16'(i), rd, exp);
    bus(0, 2'b11, 16'h0001, rd, exp);
    cr_rd_idx = 8'd4;
    #1;
    vectors++;
    if (cr_valid !== 1'b1 || cr_rd_data !== 16'h3004) begin
      miscompares++;
      $display("FAIL areset_presealed: valid=%b data=%h want 1/3004", cr_valid, cr_rd_data);
    end
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if (cr_valid !== 1'b0 || cr_rd_data !== 16'h0000 || cr_count !== 8'd0) begin
      miscompares++;
      $display("FAIL areset_sealed: valid=%b data=%h count=%0d want 0/0000/0", cr_valid, cr_rd_data, cr_count);
    end
    m_reset();
    @(negedge mclk);
    reset_n = 1'b1;
    bus(0, 2'b11, K0, rd, exp);
    bus(0, 2'b11, K1, rd, exp);
    bus(0, 2'b11, 16'h0001, rd, exp);
    vectors++;
    if (cr_valid !== 1'b1 || cr_count !== 8'd0 || cr_rd_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL areset_empty_seal: valid=%b count=%0d data=%h want 1/0/0000", cr_valid, cr_count, cr_rd_data);
    end
  endtask

  task automatic test_readback();
    logic [15:0] rd, exp;
    logic [15:0] want0, want2;
    apply_reset();
    bus(0, 2'b11, K0, rd, exp);
    bus(0, 2'b11, K1, rd, exp);
    bus(1, 2'b11, 16'h4400, rd, exp);
    bus(1, 2'b11, 16'h4411, rd, exp);
    bus(1, 2'b11, 16'h4422, rd, exp);
    bus(0, 2'b11, 16'h0001, rd, exp);
    bus(2, 2'b11, 16'h0002, rd, exp);
    want2 = RB ? 16'h4422 : 16'h0000;
    want0 = RB ? 16'h4400 : 16'h0000;
    bus(1, 2'b00, 16'h0, rd, exp);
    vectors++;
    if (rd !== want2) begin
      miscompares++;
      $display("FAIL readback_first: got %h want %h", rd, want2);
    end
    bus(1, 2'b00, 16'h0, rd, exp);
    vectors++;
    if (rd !== want0) begin
      miscompares++;
      $display("FAIL readback_wrap: got %h want %h", rd, want0);
    end
  endtask

  task automatic test_random();
    logic [15:0] rd, exp, d;
    logic [1:0]  we;
    int          off, r;
    for (int round = 0; round < 4; round++) begin
      apply_reset();
      for (int n = 0; n < 150; n++) begin
        r   = int'($urandom_range(0, 19));
        off = (r < 9) ? 0 : (r < 17) ? 1 : (r < 18) ? 2 : (r < 19) ? 3 : -1;
        r   = int'($urandom_range(0, 9));
        we  = (r < 6) ? 2'b11 : (r < 9) ? 2'b00 : 2'($urandom_range(1, 2));
        r   = int'($urandom_range(0, 9));
        d   = (r < 3) ? K0 : (r < 6) ? K1 : (r < 7) ? 16'h0001 : 16'($urandom);
        if (off == 2) d = 16'($urandom_range(0, 17));
        cr_rd_idx = 8'($urandom_range(0, 18));
        bus(off, we, d, rd, exp);
        vectors++;
        if (rd !== exp || cr_count !== 8'(m_tab.size()) || cr_valid !== (m_state == 3) ||
            cr_rd_data !== m_entry(int'(cr_rd_idx))) begin
          miscompares++;
          $display("FAIL random_r%0d_n%0d: dout=%h/%h count=%0d/%0d valid=%b/%b rd=%h/%h", round, n,
                   rd, exp, cr_count, m_tab.size(), cr_valid, (m_state == 3), cr_rd_data, m_entry(int'(cr_rd_idx)));
        end
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_basic_seal();
    test_bad_sequence();
    test_back_to_back();
    test_partial_we();
    test_async_reset();
    test_readback();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cr_writer.md
# cr_writer

Runtime programming port for the CR (critical region) definition table. Where the CR table is otherwise fixed at build time from a memory image, this block lets trusted firmware write the table over the openMSP430 peripheral bus through a key-guarded unlock sequence. It seals the table once loading ends and then presents it read-only to the CR/UCC monitoring logic.

## Interface
Parameters:
- ENTRIES, 16: number of 16-bit CR entries; 1..255.
- BASE_ADDR, 14'h00C8: peripheral word address of register 0; registers occupy BASE_ADDR+0..+2.
- KEY0, 16'hA5C3: first unlock key.
- KEY1, 16'h5A3C: second unlock key.

Ports:
- mclk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- per_addr  in  14  peripheral word address.
- per_din  in  16  peripheral write data.
- per_en  in  1  peripheral access strobe.
- per_we  in  2  byte write enables; 2'b00 = read.
- per_dout  out  16  peripheral read data; 0 when not addressed.
- cr_rd_idx  in  8  entry index requested by the monitor.
- cr_rd_data  out  16  entry at cr_rd_idx.
- cr_count  out  8  number of entries loaded.
- cr_valid  out  1  table sealed and usable.

## Operation
Registers, word offsets from BASE_ADDR:
- 0 CTRL/STAT:
  - Write: key or command.
  - Read: {err, state[1:0], 5'b0, count[7:0]}.
- 1 DATA: write appends an entry.
- 2 INDEX: readback pointer; see Configuration.

A write requires per_en=1 with an address hit. Only per_we=2'b11 counts as a write. Any other non-zero per_we to offsets 0 or 1 is ignored and sets err.

State machine:
- IDLE (2'b00):
  - CTRL write of KEY0 -> ARMED.
  - Any other write is ignored.
- ARMED (2'b01):
  - CTRL write of KEY1 -> LOAD; count cleared to 0.
  - Any other CTRL write, or any DATA write -> IDLE and set err.
- LOAD (2'b10):
  - DATA write stores per_din at entry[count], then count increments.
  - When count reaches ENTRIES -> SEALED in the same edge as the last store.
  - CTRL write of 16'h0001 -> SEALED. This is legal with count=0.
  - Any other CTRL write -> IDLE, set err, count cleared.
- SEALED (2'b11):
  - All writes are ignored; err is not set.
  - Only reset leaves this state.

Other rules:
- err is sticky and is cleared only by reset.
- cr_valid = (state == SEALED).
- cr_rd_data = entry[cr_rd_idx] when cr_valid=1 and cr_rd_idx < count; otherwise 16'h0000. This path is combinational.
- Entries at index >= count are never exposed.

## Timing
- Reset values:
  - state IDLE, count 0, err 0, all entries 16'h0000, readback pointer 0.
  - cr_valid 0, cr_count 0, per_dout 0, cr_rd_data 0.
- Reset assertion is asynchronous: state, count, err and entries clear immediately, including mid-LOAD, and cr_valid drops with no clock edge.
- Write effects become visible on the first edge after the write cycle. A STAT read in the following cycle shows the new state and count.
- per_dout is combinational in the access cycle. It is 0 whenever per_en=0, per_we!=0, or there is no address hit.
- The bus allows one access per cycle, so there are no simultaneous bus events. The monitor read port is independent and never stalls the bus.
- DATA writes sustain one entry per cycle with no back-pressure.

## Configuration
- CR_READBACK_EN defined:
  - INDEX is read/write; the pointer is 8 bits.
  - A DATA read returns entry[INDEX] when SEALED and INDEX < count, otherwise 0.
  - Each DATA read post-increments INDEX, wrapping to 0 after count-1.
- CR_READBACK_EN not defined:
  - INDEX writes are ignored and INDEX reads return 0.
  - DATA reads return 0.
  - No readback mux is synthesized.

## Test plan
- Reset, then write KEY0, KEY1, and DATA 16'h1000, 16'h1010, 16'h1020, then CTRL 16'h0001:
  - STAT reads 16'h6003; cr_valid=1.
  - cr_rd_idx=1 gives 16'h1010; cr_rd_idx=3 gives 0.
- Write KEY0, then DATA 16'h1234:
  - State returns to IDLE and STAT reads 16'h8000.
  - A later KEY0, KEY1 sequence still reaches LOAD (STAT 16'hC000).
- Unlock, then write 16 back-to-back DATA words:
  - Auto-seal on the 16th edge; STAT reads 16'h6010.
  - A 17th DATA write is ignored and count stays 16.
- In LOAD, perform a DATA write with per_we=2'b01:
  - No store; err=1; count unchanged.
- Assert reset_n low mid-LOAD after 5 entries:
  - cr_count=0, cr_valid=0 and all entries 0 immediately, with no clock edge.
- With CR_READBACK_EN, seal 3 entries, write INDEX=2, then read DATA twice:
  - Returns entry[2], then entry[0] (wrap).
  - Without the macro, both reads return 0.
